// File: rtl/snake_pkg.sv
// Shared constants for the snake board reader: dmem geometry, defaults and FSM encoding.
package snake_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;

    localparam logic [DMEM_ADDR_W-1:0] DEF_BASE_ADDR = 12'd0;
    localparam int                     DEF_NUM_WORDS = 10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;

    // Index width that stays legal for a single-word board.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snake_shadow_buf.sv
// Shadow register file: one word written per capture, all words visible in parallel for commit.
module snake_shadow_buf
    import snake_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int IDX_W     = idx_width(NUM_WORDS)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [IDX_W-1:0]                 wr_idx,
    input  logic [DMEM_DATA_W-1:0]           wr_data,
    output logic [NUM_WORDS*DMEM_DATA_W-1:0] rd_all
);

    logic [DMEM_DATA_W-1:0] words [NUM_WORDS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WORDS; i++) words[i] <= '0;
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_flat
        assign rd_all[i*DMEM_DATA_W +: DMEM_DATA_W] = words[i];
    end

endmodule

// File: rtl/snake_board_reader.sv
// Snapshots the snake board from dmem each frame and commits it atomically to the renderer.
// Optional SNAKE_READ_ACK_EN adds a one-cycle write of the frame count after every commit.
module snake_board_reader
    import snake_pkg::*;
#(
    parameter logic [DMEM_ADDR_W-1:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int                     NUM_WORDS    = DEF_NUM_WORDS,
    parameter int                     READ_LATENCY = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             frame_start,
    input  logic [DMEM_DATA_W-1:0]           q_dmem_toVGA,
    output logic [DMEM_ADDR_W-1:0]           address_dmem_fromVGA,
    output logic [DMEM_DATA_W-1:0]           data_fromVGA,
    output logic                             wren_fromVGA,
    output logic [NUM_WORDS*DMEM_DATA_W-1:0] snake_data,
    output logic                             snake_valid,
    output logic                             busy
);

    localparam int               IDX_W    = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [2:0]                       state;
    logic [IDX_W-1:0]                 rd_idx;
    logic [IDX_W-1:0]                 cap_idx;
    logic                             pending;
    logic                             issue_p0;
    logic                             vld_p1;
    logic                             vld_p2;
    logic                             cap_en;
    logic [NUM_WORDS*DMEM_DATA_W-1:0] shadow_all;

`ifdef SNAKE_READ_ACK_EN
    logic [15:0] frame_count;
    assign issue_p0 = (state == ST_READ);
`else
    // A queued snapshot issues word 0 during COMMIT so back-to-back frames lose no cycle.
    assign issue_p0 = (state == ST_READ) || ((state == ST_COMMIT) && pending);
    assign data_fromVGA = '0;
    assign wren_fromVGA = 1'b0;
`endif

    assign busy   = (state != ST_IDLE);
    assign cap_en = (READ_LATENCY >= 2) ? vld_p2 : vld_p1;

    // Stage p0 -> p1/p2: address issue delayed to line up with returning read data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            cap_idx <= '0;
        end else begin
            vld_p1 <= issue_p0;
            vld_p2 <= vld_p1;
            if (cap_en) cap_idx <= (cap_idx == LAST_IDX) ? '0 : cap_idx + 1'b1;
        end
    end

    snake_shadow_buf #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_shadow (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (cap_en),
        .wr_idx  (cap_idx),
        .wr_data (q_dmem_toVGA),
        .rd_all  (shadow_all)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= ST_IDLE;
            rd_idx               <= '0;
            pending              <= 1'b0;
            address_dmem_fromVGA <= '0;
            snake_data           <= '0;
            snake_valid          <= 1'b0;
`ifdef SNAKE_READ_ACK_EN
            data_fromVGA         <= '0;
            wren_fromVGA         <= 1'b0;
            frame_count          <= '0;
`endif
        end else begin
            snake_valid <= 1'b0;
            if (frame_start && (state != ST_IDLE)) pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state                <= ST_READ;
                        rd_idx               <= '0;
                        address_dmem_fromVGA <= BASE_ADDR;
                    end
                end
                ST_READ: begin
                    if (rd_idx == LAST_IDX) begin
                        state <= ST_DRAIN;
                    end else begin
                        rd_idx               <= rd_idx + 1'b1;
                        address_dmem_fromVGA <= address_dmem_fromVGA + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cap_en && (cap_idx == LAST_IDX)) begin
                        state <= ST_COMMIT;
`ifndef SNAKE_READ_ACK_EN
                        if (pending || frame_start) begin
                            rd_idx               <= '0;
                            address_dmem_fromVGA <= BASE_ADDR;
                        end
`endif
                    end
                end
                ST_COMMIT: begin
                    snake_data  <= shadow_all;
                    snake_valid <= 1'b1;
                    pending     <= 1'b0;
`ifdef SNAKE_READ_ACK_EN
                    frame_count          <= frame_count + 16'd1;
                    state                <= ST_ACK;
                    address_dmem_fromVGA <= DMEM_ADDR_W'(BASE_ADDR + NUM_WORDS);
                    data_fromVGA         <= {16'h0, frame_count + 16'd1};
                    wren_fromVGA         <= 1'b1;
`else
                    if (pending) begin
                        if (rd_idx == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end else begin
                            state                <= ST_READ;
                            rd_idx               <= rd_idx + 1'b1;
                            address_dmem_fromVGA <= address_dmem_fromVGA + 1'b1;
                        end
                    end else if (frame_start) begin
                        state                <= ST_READ;
                        rd_idx               <= '0;
                        address_dmem_fromVGA <= BASE_ADDR;
                    end else begin
                        state <= ST_IDLE;
                    end
`endif
                end
`ifdef SNAKE_READ_ACK_EN
                ST_ACK: begin
                    wren_fromVGA <= 1'b0;
                    data_fromVGA <= '0;
                    pending      <= 1'b0;
                    if (pending || frame_start) begin
                        state                <= ST_READ;
                        rd_idx               <= '0;
                        address_dmem_fromVGA <= BASE_ADDR;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
